// File: rtl/decode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_sequencer_pkg
// Description : Types and constants shared by the decode sequencer and its
//               prefetch byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_sequencer_pkg;

  // Sequencer phases: wait for a full window, strobe pre-decode, capture its
  // result, then hold the decoded instruction until execution retires it.
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_DECODE = 2'd1,
    ST_LATCH  = 2'd2,
    ST_ISSUED = 2'd3
  } seq_state_e;

  // Pre-decode needs opcode, modrm and one more byte before it can run.
  localparam int unsigned MIN_WINDOW = 3;

endpackage
`default_nettype wire

// File: rtl/decode_sequencer_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Circular byte queue with 0/1/2-byte push, variable-size pop
//               and a MIN_WINDOW-byte peek at the read pointer. Pointers wrap
//               by explicit compare so DEPTH need not be a power of two.
//               The caller guarantees pushes fit and pops never exceed the
//               bytes available (including bytes pushed the same cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo
  import decode_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 6,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_i,
  input  logic          clear_i,
  input  logic [1:0]    push_n_i,
  input  logic [15:0]   push_data_i,
  input  logic [CW-1:0] pop_n_i,
  output logic [CW-1:0] count_o,
  output logic [7:0]    peek_o [MIN_WINDOW]
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] w_wr_plus1;

  // Advance a pointer by n (n <= DEPTH) with a single compare-and-subtract.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr,
                                            input logic [CW-1:0] n);
    int unsigned sum;
    sum = 32'(ptr) + 32'(n);
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PW'(sum);
  endfunction

  // Next pointer and occupancy values for the push/pop requested this cycle.
  always_comb begin
    w_wr_plus1 = ptr_add(wr_q, CW'(1));
    wr_d       = ptr_add(wr_q, CW'(push_n_i));
    rd_d       = ptr_add(rd_q, pop_n_i);
    count_d    = count_q + CW'(push_n_i) - pop_n_i;
  end

  // Byte storage, pointers and occupancy; clear empties the queue but leaves
  // stale bytes in place (only reset zeroes the storage).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (ce_i) begin
      if (clear_i) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        if (push_n_i != 2'd0) mem_q[wr_q]       <= push_data_i[7:0];
        if (push_n_i == 2'd2) mem_q[w_wr_plus1] <= push_data_i[15:8];
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        count_q <= count_d;
      end
    end
  end

  assign count_o = count_q;

  generate
    for (genvar k = 0; k < int'(MIN_WINDOW); k++) begin : g_peek
      assign peek_o[k] = mem_q[ptr_add(rd_q, CW'(k))];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : decode_sequencer
// Description : Owns the instruction prefetch queue, paces the pre-decoder
//               clock enable, holds the decoded result until execution
//               retires it, pops retired bytes and refills from the bus.
//               QUEUE_BYTES must lie in 4..7 (queue_count is 3 bits wide).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int unsigned QUEUE_BYTES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        flush,
  output logic        fetch_req,
  input  logic        fetch_odd,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic [7:0]  q0,
  output logic [7:0]  q1,
  output logic [7:0]  q2,
  output logic        decode_ce,
  input  logic        valid_op,
  output logic        op_ready,
  output logic        illegal_op,
  input  logic        retire,
  input  logic [2:0]  retire_size,
  output logic [2:0]  queue_count
);

  localparam int unsigned   CW      = $clog2(QUEUE_BYTES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_BYTES);
  localparam logic [CW-1:0] WIN_C   = CW'(MIN_WINDOW);

  seq_state_e    state_q;
  logic          decode_ce_q;
  logic          op_ready_q;
  logic          illegal_op_q;
  logic          fetch_req_q, fetch_req_d;
  logic          discard_q, discard_d;
  logic          pend_q;
  logic [CW-1:0] pend_size_q;
  logic [CW-1:0] count_d;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic [1:0]    w_push_want;
  logic [1:0]    w_push_n;
  logic          w_accept;
  logic [CW-1:0] w_avail;
  logic          w_ret_live;
  logic [CW-1:0] w_ret_size;
  logic          w_pop_ok;
  logic [CW-1:0] w_pop_n;
  logic [7:0]    w_peek [MIN_WINDOW];

  prefetch_fifo #(
    .DEPTH (QUEUE_BYTES)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .ce_i        (ce),
    .clear_i     (flush),
    .push_n_i    (w_push_n),
    .push_data_i (fetch_data),
    .pop_n_i     (w_pop_n),
    .count_o     (w_count),
    .peek_o      (w_peek)
  );

  // Push/pop sizing, discard tracking and the next fetch request. A retire
  // may be satisfied by bytes arriving in the same cycle; excess bytes of an
  // overflowing ack are dropped.
  always_comb begin
    w_accept    = fetch_ack && !flush && !discard_q;
    w_free      = DEPTH_C - w_count;
    w_push_want = fetch_odd ? 2'd1 : 2'd2;
    if (!w_accept)                         w_push_n = 2'd0;
    else if (CW'(w_push_want) > w_free)    w_push_n = 2'(w_free);
    else                                   w_push_n = w_push_want;
    w_avail     = w_count + CW'(w_push_n);

    w_ret_live  = (state_q == ST_ISSUED) && (retire || pend_q);
    w_ret_size  = retire ? CW'(retire_size) : pend_size_q;
    w_pop_ok    = w_ret_live && !flush && (w_ret_size <= w_avail);
    w_pop_n     = w_pop_ok ? w_ret_size : '0;

    count_d     = flush ? '0 : (w_avail - w_pop_n);

    // A flush while a requested fetch is still unanswered poisons its ack.
    if (flush) discard_d = !fetch_ack && (discard_q || fetch_req_q);
    else       discard_d = discard_q && !fetch_ack;

    fetch_req_d = !discard_d && ((DEPTH_C - count_d) >= CW'(w_push_want));
  end

  // Sequencer FSM with registered decode strobe, result flags and fetch request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FILL;
      decode_ce_q  <= 1'b0;
      op_ready_q   <= 1'b0;
      illegal_op_q <= 1'b0;
      fetch_req_q  <= 1'b0;
      discard_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_size_q  <= '0;
    end else if (ce) begin
      fetch_req_q <= fetch_req_d;
      discard_q   <= discard_d;
      decode_ce_q <= 1'b0;
      if (flush) begin
        state_q      <= ST_FILL;
        op_ready_q   <= 1'b0;
        illegal_op_q <= 1'b0;
        pend_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_FILL: begin
            if (w_count >= WIN_C) begin
              state_q     <= ST_DECODE;
              decode_ce_q <= 1'b1;
            end
          end
          ST_DECODE: begin
            state_q <= ST_LATCH;
          end
          ST_LATCH: begin
            illegal_op_q <= ~valid_op;
            op_ready_q   <= 1'b1;
            state_q      <= ST_ISSUED;
          end
          ST_ISSUED: begin
            if (w_pop_ok) begin
              op_ready_q   <= 1'b0;
              illegal_op_q <= 1'b0;
              pend_q       <= 1'b0;
              if (count_d >= WIN_C) begin
                state_q     <= ST_DECODE;
                decode_ce_q <= 1'b1;
              end else begin
                state_q <= ST_FILL;
              end
            end else if (w_ret_live) begin
              // Instruction tail still being fetched: remember the retire.
              pend_q      <= 1'b1;
              pend_size_q <= w_ret_size;
            end
          end
          default: state_q <= ST_FILL;
        endcase
      end
    end
  end

  // An accepted ack must never carry more bytes than the queue can hold.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (ce && w_accept) |-> (CW'(w_push_want) <= w_free));

  assign fetch_req   = fetch_req_q;
  assign decode_ce   = decode_ce_q;
  assign op_ready    = op_ready_q;
  assign illegal_op  = illegal_op_q;
  assign q0          = w_peek[0];
  assign q1          = w_peek[1];
  assign q2          = w_peek[2];
  assign queue_count = 3'(w_count);

endmodule
`default_nettype wire

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Owns the instruction prefetch queue and drives the three-byte window into the pre-decoder.
- Decides when the pre-decoder clock-enable fires, then holds the decoded result until execution retires it.
- Pops the retired instruction's bytes from the queue and refills the queue from the bus interface.
- Sits between the bus unit (fetch handshake), pre_decode (q0..q2, ce) and the execution unit (issue/retire handshake).

Parameters:
- QUEUE_BYTES, 6, prefetch queue depth in bytes (≥4; need not be a power of two).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ce  input  1  global clock enable; all state holds when low
- flush  input  1  discard queue contents and any outstanding fetch (branch/interrupt)
- fetch_req  output  1  request next bus fetch
- fetch_odd  input  1  next fetch address is odd (delivers 1 byte)
- fetch_ack  input  1  fetch data valid this cycle
- fetch_data  input  16  fetched bytes, low byte first
- q0, q1, q2  output  8 each  decode window, oldest byte in q0
- decode_ce  output  1  one-cycle enable to pre_decode
- valid_op  input  1  from pre_decode, valid one cycle after decode_ce
- op_ready  output  1  decoded instruction available to execution
- illegal_op  output  1  qualifies op_ready: decoded op invalid
- retire  input  1  execution accepts and finishes the instruction
- retire_size  input  3  total bytes to pop (opcode+modrm+disp+imm), 1..QUEUE_BYTES
- queue_count  output  3  bytes currently held

Behaviour:
- Reset values: queue_count=0, fetch_req=0, decode_ce=0, op_ready=0, illegal_op=0, q0..q2=0, rd/wr pointers=0, discard flag=0, state=FILL.
- Queue: circular byte buffer; pointers wrap modulo QUEUE_BYTES by explicit compare, not bit truncation.
- q0..q2 are combinational reads at rd_ptr, rd_ptr+1 and rd_ptr+2 (mod depth). Bytes beyond queue_count read as stale data; this is legal.
- Fetch request: fetch_req=1 when not discarding and free space ≥ (fetch_odd ? 1 : 2).
- Fetch push, on fetch_ack:
  - odd fetch: push fetch_data[7:0] only;
  - even fetch: push [7:0], then [15:8].
- Retire pop: on retire, pop retire_size bytes. A push and a pop in the same cycle are applied together: count += pushed − popped.
- Overflow: an ack that would overflow the queue is a protocol error. Assert in simulation; the RTL drops the excess bytes.
- FSM:
  - FILL: wait for queue_count ≥ 3 → DECODE.
  - DECODE: decode_ce=1 for one cycle → LATCH.
  - LATCH: sample valid_op into illegal_op, set op_ready=1 → ISSUED.
  - ISSUED: hold op_ready. On retire:
    - if retire_size > queue_count, wait in ISSUED with op_ready held until enough bytes arrive (disp/imm still fetching), then pop;
    - after the pop: if the remaining count (plus any push this cycle) ≥ 3 → DECODE, else → FILL.
  - op_ready drops the cycle after a successful pop.
- Decode latency: 2 cycles from window valid to op_ready.
- Flush (priority over everything except reset):
  - next cycle: count=0, pointers=0, op_ready=0, state=FILL;
  - if a fetch is outstanding (req accepted, ack pending), set the discard flag; the next ack is dropped and the flag cleared.
  - flush together with retire: flush wins, no pop.
  - flush together with fetch_ack: that data is dropped.
- ce low: no state changes; fetch_ack and retire are ignored by contract.
- Reset mid-instruction: immediate return to reset values; no pending discard survives.

Decomposition:
- Shared types package:
  - sequencer state enum (FILL, DECODE, LATCH, ISSUED);
  - constant for the 3-byte minimum decode window.
- Natural sub-module: prefetch_fifo. It is the byte ring buffer with dual-byte push, variable pop and a 3-byte peek.
- The FSM and fetch/discard logic stay in decode_sequencer.

Test Plan:
- Cold start: even fetches 0x0201, 0x0403 → decode_ce pulses one cycle after count reaches 3; q0/q1/q2 = 01/02/03; op_ready two cycles later.
- Retire with retire_size=2 while count=4 → count=2, state FILL. After the next even ack: count=4, q0 = old byte 3.
- Wrap-around: 10 sequential fetches with retire_size=1,2,3 mix → q0 always equals the byte-stream sequence across pointer wrap at 6.
- Stalled retire: retire_size=5 with count=3 → op_ready held, no pop. Pop happens on the cycle the count reaches 5 via acks.
- Flush with fetch outstanding → count=0 next cycle; the following ack with 0xBEEF is ignored; the subsequent ack is queued normally.
- Odd fetch and illegal op: fetch_odd=1, ack 0x??0F, then even fetch → only 0x0F pushed. valid_op=0 at LATCH → illegal_op=1 with op_ready=1.
